// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - sequential instruction fetch with credit-based prefetch FIFO and redirect flush
module fetch_prefetch_unit #(
    parameter int              XLEN            = 32,
    parameter int              ILEN            = 32,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            areset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
    logic [ILEN-1:0] data_mem [FIFO_DEPTH];

    logic [CW:0] credit_used;
    logic        issue;
    logic        keep;
    logic        pop;

    // Responses still to be dropped hold no FIFO slot, so they are excluded from the credit.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding} - {1'b0, drop_cnt};

    assign imem_req_valid = !areset && !redirect_valid
                            && (outstanding < CW'(MAX_OUTSTANDING))
                            && (credit_used < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign issue = imem_req_valid && imem_req_ready;
    assign keep  = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign pop   = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = (fifo_count != '0);
    assign instr       = data_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (keep) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            data_mem[wr_ptr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_pc & ~XLEN'(3);
            rsp_pc      <= redirect_pc & ~XLEN'(3);
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= outstanding - CW'(imem_rsp_valid);
            // Every request still in flight after this cycle belongs to the old stream.
            drop_cnt    <= outstanding - CW'(imem_rsp_valid);
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (keep) begin
                rsp_pc <= rsp_pc + XLEN'(4);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count  <= fifo_count + CW'(keep) - CW'(pop);
            outstanding <= outstanding + CW'(issue) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (areset)
        !(keep && !pop && (fifo_count == CW'(FIFO_DEPTH))));
    a_count_bound: assert property (@(posedge clk) disable iff (areset)
        fifo_count <= CW'(FIFO_DEPTH));
    a_outstanding: assert property (@(posedge clk) disable iff (areset)
        outstanding <= CW'(MAX_OUTSTANDING));
    a_drop_bound: assert property (@(posedge clk) disable iff (areset)
        drop_cnt <= outstanding);
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - randomized bench for fetch_prefetch_unit against a queue-based model
module tb_fetch_prefetch_unit;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    fetch_prefetch_unit #(
        .XLEN(32), .ILEN(32), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .areset(areset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          drop;
    } req_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    req_t        infl[$];
    ent_t        fq[$];
    logic [31:0] pop_log[$];
    logic [31:0] m_fetch_pc;
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    int          first_hs = -1, first_iv = -1;
    int          n_tests = 0, n_fail = 0;

    bit          drv_req_ready = 1'b1;
    bit          drv_instr_ready = 1'b1;
    bit          drv_redirect = 1'b0;
    logic [31:0] drv_redirect_pc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int kept_inflight();
        int k = 0;
        foreach (infl[i]) if (!infl[i].drop) k++;
        return k;
    endfunction

    // One clock: compare, drive, then advance the model to the state after the next rising edge.
    task automatic step();
        bit   rsp;
        bit   exp_rv;
        req_t r;
        ent_t e;
        chk("instr_valid", instr_valid, fq.size() != 0);
        if (fq.size() != 0) begin
            chk("instr_pc", instr_pc, fq[0].pc);
            chk("instr", instr, fq[0].data);
        end
        if (first_iv < 0 && instr_valid) first_iv = cyc;
        imem_req_ready = drv_req_ready;
        instr_ready    = drv_instr_ready;
        redirect_valid = drv_redirect;
        redirect_pc    = drv_redirect_pc;
        rsp = (infl.size() != 0) && (infl[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? (infl[0].addr ^ MAGIC) : $urandom;
        #1;
        exp_rv = !drv_redirect && (infl.size() < MAXO) && ((fq.size() + kept_inflight()) < DEPTH);
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", imem_req_addr, m_fetch_pc);
        if (first_hs < 0 && exp_rv && drv_req_ready) first_hs = cyc;
        r = '{addr: '0, due: 0, drop: 1'b1};
        if (rsp) r = infl.pop_front();
        if (drv_redirect) begin
            fq.delete();
            foreach (infl[i]) infl[i].drop = 1'b1;
            m_fetch_pc = drv_redirect_pc & ~32'h3;
        end else begin
            if (fq.size() != 0 && drv_instr_ready) begin
                e = fq.pop_front();
                pop_log.push_back(e.pc);
            end
            if (rsp && !r.drop) fq.push_back('{pc: r.addr, data: r.addr ^ MAGIC});
            if (exp_rv && drv_req_ready) begin
                infl.push_back('{addr: m_fetch_pc, due: cyc + int'($urandom_range(lat_max, lat_min)), drop: 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        areset         = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        repeat (2) @(negedge clk);
        fq.delete();
        infl.delete();
        pop_log.delete();
        m_fetch_pc = 32'h0;
        first_hs = -1;
        first_iv = -1;
        drv_redirect = 1'b0;
        areset = 1'b0;
        #1;
        chk("rst_first_addr", imem_req_addr, 32'h0);
    endtask

    initial begin
        @(negedge clk);
        // 1: straight-line streaming at 1-cycle latency
        do_reset();
        drv_req_ready = 1; drv_instr_ready = 1; lat_min = 1; lat_max = 1;
        repeat (12) step();
        chk("t1_latency", 64'(first_iv - first_hs), 64'd2);
        chk("t1_no_gaps", 64'(pop_log.size()), 64'(cyc - first_iv));
        for (int k = 0; k < 8; k++) chk("t1_pc_seq", pop_log[k], 32'(4 * k));

        // 2: decode stalled fills exactly FIFO_DEPTH entries
        do_reset();
        drv_instr_ready = 0;
        repeat (20) step();
        chk("t2_head_pc", instr_pc, 32'h0);
        chk("t2_req_low", imem_req_valid, 1'b0);
        chk("t2_fifo_full", 64'(fq.size()), 64'(DEPTH));
        drv_instr_ready = 1;
        repeat (10) step();
        for (int k = 0; k < 8; k++) chk("t2_resume_seq", pop_log[k], 32'(4 * k));

        // 3: redirect with two requests in flight at latency 3
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 40 && !(infl.size() == 2 && kept_inflight() == 2); i++) step();
        chk("t3_setup", 64'(kept_inflight()), 64'd2);
        drv_redirect = 1; drv_redirect_pc = 32'h100;
        step();
        drv_redirect = 0;
        pop_log.delete();
        repeat (16) step();
        chk("t3_first", pop_log[0], 32'h100);
        chk("t3_second", pop_log[1], 32'h104);

        // 4: redirect coinciding with a response and a pop
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 40 && !(infl.size() != 0 && infl[0].due <= cyc && fq.size() != 0); i++) step();
        chk("t4_setup", 64'(fq.size() != 0), 64'd1);
        drv_redirect = 1; drv_redirect_pc = 32'h0000_0A4C;
        step();
        drv_redirect = 0;
        chk("t4_empty", instr_valid, 1'b0);
        pop_log.delete();
        repeat (10) step();
        chk("t4_first", pop_log[0], 32'h0000_0A4C);

        // 5: memory stall holds the address; redirect during stall realigns it
        do_reset();
        repeat (6) step();
        drv_req_ready = 0;
        repeat (3) step();
        chk("t5_valid_in_stall", imem_req_valid, 1'b1);
        begin
            logic [31:0] stall_addr;
            stall_addr = imem_req_addr;
            for (int i = 0; i < 5; i++) begin
                step();
                chk("t5_addr_hold", imem_req_addr, stall_addr);
            end
        end
        drv_redirect = 1; drv_redirect_pc = 32'h203;
        step();
        drv_redirect = 0;
        pop_log.delete();
        step();
        chk("t5_aligned_addr", imem_req_addr, 32'h200);
        drv_req_ready = 1;
        repeat (8) step();
        chk("t5_first_pc", pop_log[0], 32'h200);

        // 6: asynchronous reset with three buffered entries
        drv_instr_ready = 0;
        for (int i = 0; i < 20 && fq.size() != 3; i++) step();
        chk("t6_setup", instr_valid, 1'b1);
        #2;
        do_reset();
        drv_instr_ready = 1;
        repeat (6) step();
        chk("t6_restart_pc", pop_log[0], 32'h0);

        // random traffic
        for (int blk = 0; blk < 30; blk++) begin
            lat_min = int'($urandom_range(3, 1));
            lat_max = lat_min + int'($urandom_range(3, 0));
            for (int i = 0; i < 100; i++) begin
                drv_req_ready   = ($urandom_range(99) < 70);
                drv_instr_ready = ($urandom_range(99) < 60);
                drv_redirect    = ($urandom_range(99) < 4);
                drv_redirect_pc = $urandom;
                if ($urandom_range(99) < 5) drv_redirect_pc = 32'hFFFF_FFF4 | {30'b0, 2'($urandom)};
                step();
            end
        end
        drv_redirect = 0;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
